psum_accumulator: RTL

//   Sequential counterpart to the combinational signed adder: consumes a stream of signed

---
 rtl/psum_accumulator.sv | 106 ++++++++++
 1 files changed

// File: rtl/psum_accumulator.sv
// Frame accumulator for signed partial sums: adds or subtracts each accepted sample into a
// saturating accumulator and presents one result per LEN-sample frame over valid/ready.
module psum_accumulator #(
   parameter int WIDTH_IN  = 8,
   parameter int WIDTH_ACC = 16,
   parameter int LEN       = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [WIDTH_IN-1:0]        IN_DATA,
   input  logic                       SUB,
   input  logic                       CLEAR,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [WIDTH_ACC-1:0]       OUT_DATA,
   output logic                       OVF,
   output logic [$clog2(LEN+1)-1:0]   COUNT
);

   localparam int CW = $clog2(LEN+1);
   localparam logic [CW-1:0]        LAST = CW'(LEN-1);
   localparam logic [WIDTH_ACC-1:0] MAXV = {1'b0, {(WIDTH_ACC-1){1'b1}}};
   localparam logic [WIDTH_ACC-1:0] MINV = {1'b1, {(WIDTH_ACC-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t               state, state_n;
   logic [WIDTH_ACC-1:0] acc, acc_n;
   logic [WIDTH_ACC-1:0] out_data_n;
   logic [CW-1:0]        count_n;
   logic                 ovf_n;
   logic [WIDTH_ACC:0]   ext, operand, sum;
   logic                 clamp;
   logic [WIDTH_ACC-1:0] sat;

   // One guard bit makes the sum exact, including subtraction of the most negative sample.
   always_comb begin
      ext     = {{(WIDTH_ACC+1-WIDTH_IN){IN_DATA[WIDTH_IN-1]}}, IN_DATA};
      operand = SUB ? ~ext : ext;
      sum     = {acc[WIDTH_ACC-1], acc} + operand + {{WIDTH_ACC{1'b0}}, SUB};
      clamp   = sum[WIDTH_ACC] ^ sum[WIDTH_ACC-1];
      if (clamp)
         sat = sum[WIDTH_ACC] ? MINV : MAXV;
      else
         sat = sum[WIDTH_ACC-1:0];
   end

   assign IN_READY  = (state != HOLD) && !CLEAR;
   assign OUT_VALID = (state == HOLD);

   always_comb begin
      state_n    = state;
      acc_n      = acc;
      count_n    = COUNT;
      ovf_n      = OVF;
      out_data_n = OUT_DATA;
      unique case (state)
         IDLE, ACCUM: begin
            if (CLEAR) begin
               state_n = IDLE;
               acc_n   = '0;
               count_n = '0;
               ovf_n   = 1'b0;
            end else if (IN_VALID) begin
               acc_n = sat;
               ovf_n = OVF | clamp;
               if (COUNT == LAST) begin
                  state_n    = HOLD;
                  count_n    = '0;
                  out_data_n = sat;
               end else begin
                  state_n = ACCUM;
                  count_n = COUNT + CW'(1);
               end
            end
         end
         HOLD: begin
            if (OUT_READY) begin
               state_n = IDLE;
               acc_n   = '0;
               ovf_n   = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         acc      <= '0;
         COUNT    <= '0;
         OVF      <= 1'b0;
         OUT_DATA <= '0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         COUNT    <= count_n;
         OVF      <= ovf_n;
         OUT_DATA <= out_data_n;
      end
   end

endmodule
